zigbee_cordic_rotator: RTL and testbench

- Iterative CORDIC engine in rotation mode: rotates the vector (xin, yin) by a commanded phase win and returns the rotated coordinates.
- Counterpart of the vectoring-mode CORDIC stages used on the receive side. Used on the transmit side for O-QPSK half-sine/carrier phase generation, e.g. xin = amplitude, yin = 0 gives cos/sin.
- A single shared shift-add datapath performs one micro-rotation per clock, under valid/ready handshakes on both sides.

---
 rtl/zigbee_cordic_rotator.sv | 149 ++++++++++++++
 tb/tb_zigbee_cordic_rotator.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/zigbee_cordic_rotator.sv
`timescale 1ns / 1ps
// Iterative rotation-mode CORDIC: rotates (xin, yin) by a binary angle win, one
// micro-rotation per clock, with valid/ready handshakes on input and output.
module zigbee_cordic_rotator #(
  parameter int unsigned XY_SIZE = 16,
  parameter int unsigned W_SIZE  = 16,
  parameter int unsigned NB_ITER = 12
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [XY_SIZE-1:0]        xin_i,
  input  logic [XY_SIZE-1:0]        yin_i,
  input  logic [W_SIZE-1:0]         win_i,
  input  logic                      in_valid_i,
  output logic                      in_ready_o,
  output logic signed [XY_SIZE+1:0] xout_o,
  output logic signed [XY_SIZE+1:0] yout_o,
  output logic                      out_valid_o,
  input  logic                      out_ready_i
);

  localparam int unsigned XW       = XY_SIZE + 2;
  localparam int unsigned IterW    = (NB_ITER > 1) ? $clog2(NB_ITER) : 1;
  localparam logic [IterW-1:0] LastIter = IterW'(NB_ITER - 1);
  localparam int          AtanDrop = 32 - int'(W_SIZE);

  typedef enum logic [1:0] {StIdle, StRot, StDone} state_e;

  // atan(2^-i) as a 32-bit binary angle; beyond i = 15, atan(x) ~= x is exact enough.
  function automatic logic [31:0] atan32(input logic [31:0] i);
    logic [31:0] a;
    case (i)
      32'd0:   a = 32'h2000_0000;
      32'd1:   a = 32'h12E4_051E;
      32'd2:   a = 32'h09FB_385B;
      32'd3:   a = 32'h0511_11D4;
      32'd4:   a = 32'h028B_0D43;
      32'd5:   a = 32'h0145_D7E1;
      32'd6:   a = 32'h00A2_F61E;
      32'd7:   a = 32'h0051_7C55;
      32'd8:   a = 32'h0028_BE53;
      32'd9:   a = 32'h0014_5F2F;
      32'd10:  a = 32'h000A_2F98;
      32'd11:  a = 32'h0005_17CC;
      32'd12:  a = 32'h0002_8BE6;
      32'd13:  a = 32'h0001_45F3;
      32'd14:  a = 32'h0000_A2F9;
      32'd15:  a = 32'h0000_517D;
      default: a = 32'(64'd683565276 >> i);
    endcase
    return a;
  endfunction

  // Round the 32-bit table down to the phase width.
  function automatic logic [W_SIZE-1:0] atan_lut(input logic [31:0] i);
    logic [32:0] full;
    full = {1'b0, atan32(i)};
    if (AtanDrop > 0) begin
      full = (full + (33'd1 << (AtanDrop > 0 ? AtanDrop - 1 : 0))) >> AtanDrop;
    end
    return W_SIZE'(full);
  endfunction

  state_e                  state_q, state_d;
  logic [IterW-1:0]        iter_q, iter_d;
  logic signed [XW-1:0]    x_q, x_d, y_q, y_d;
  logic [W_SIZE-1:0]       z_q, z_d;

  logic signed [XW-1:0]    x_ext, y_ext, x_sh, y_sh;
  logic [W_SIZE-1:0]       atan_cur;

  // Sign-extend first so that negating the most negative input cannot overflow.
  assign x_ext    = {{2{xin_i[XY_SIZE-1]}}, xin_i};
  assign y_ext    = {{2{yin_i[XY_SIZE-1]}}, yin_i};
  assign x_sh     = x_q >>> iter_q;
  assign y_sh     = y_q >>> iter_q;
  assign atan_cur = atan_lut(32'(iter_q));

  always_comb begin
    state_d = state_q;
    iter_d  = iter_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid_i) begin
          // |angle| >= pi/2: rotate by pi up front so the residual converges.
          if (win_i[W_SIZE-1] ^ win_i[W_SIZE-2]) begin
            x_d = -x_ext;
            y_d = -y_ext;
            z_d = {~win_i[W_SIZE-1], win_i[W_SIZE-2:0]};
          end else begin
            x_d = x_ext;
            y_d = y_ext;
            z_d = win_i;
          end
          iter_d  = '0;
          state_d = StRot;
        end
      end
      StRot: begin
        if (!z_q[W_SIZE-1]) begin
          x_d = x_q - y_sh;
          y_d = y_q + x_sh;
          z_d = z_q - atan_cur;
        end else begin
          x_d = x_q + y_sh;
          y_d = y_q - x_sh;
          z_d = z_q + atan_cur;
        end
        if (iter_q == LastIter) begin
          iter_d  = '0;
          state_d = StDone;
        end else begin
          iter_d = iter_q + IterW'(1);
        end
      end
      StDone: begin
        if (out_ready_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      iter_q  <= '0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
    end else begin
      state_q <= state_d;
      iter_q  <= iter_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
    end
  end

  assign in_ready_o  = (state_q == StIdle);
  assign out_valid_o = (state_q == StDone);
  assign xout_o      = x_q;
  assign yout_o      = y_q;

endmodule

// File: tb/tb_zigbee_cordic_rotator.sv
`timescale 1ns / 1ps
// Bench for zigbee_cordic_rotator: directed table, backpressure, mid-rotation reset
// and a random sweep against a real-valued CORDIC reference.
module tb_zigbee_cordic_rotator;

  localparam int NB = 12;
  localparam real TOL_MODEL = 12.0;
  localparam real TOL_IDEAL = 40.0;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [15:0]        xin, yin, win;
  logic               in_valid, in_ready, out_valid, out_ready;
  logic signed [17:0] xout, yout;

  int n_checks = 0;
  int n_fail   = 0;

  int ATAN [16] = '{8192, 4836, 2555, 1297, 651, 326, 163, 81, 41, 20, 10, 5, 3, 1, 1, 0};

  typedef struct {
    string       name;
    int          xi;
    int          yi;
    logic [15:0] w;
    int          ex;
    int          ey;
  } vec_t;

  vec_t tbl [5];
  real  qx[$], qy[$];

  zigbee_cordic_rotator dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .xin_i       (xin),
    .yin_i       (yin),
    .win_i       (win),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .xout_o      (xout),
    .yout_o      (yout),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic check_near(input string nm, input int act, input real exp, input real tol);
    real d;
    n_checks++;
    d = real'(act) - exp;
    if (d > tol || d < -tol) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0.2f (tol %0.1f)", nm, act, exp, tol);
    end
  endtask

  // CORDIC rotation in real arithmetic; only the angle accumulator is integer so the
  // direction decisions follow the binary-angle table exactly.
  function automatic void cordic_model(input int xi, input int yi, input logic [15:0] w,
                                       output real xr, output real yr);
    real x, y, xn, p;
    logic signed [15:0] z;
    x = real'(xi);
    y = real'(yi);
    z = w;
    if (w[15] ^ w[14]) begin
      x = -x;
      y = -y;
      z[15] = ~z[15];
    end
    p = 1.0;
    for (int i = 0; i < NB; i++) begin
      if (z >= 0) begin
        xn = x - y * p;
        y  = y + x * p;
        z  = z - 16'(ATAN[i]);
      end else begin
        xn = x + y * p;
        y  = y - x * p;
        z  = z + 16'(ATAN[i]);
      end
      x = xn;
      p = p * 0.5;
    end
    xr = x;
    yr = y;
  endfunction

  // Present a vector and return just after the accept edge, scrambling the inputs.
  task automatic send(input int xi, input int yi, input logic [15:0] w);
    int n;
    xin = 16'(xi);
    yin = 16'(yi);
    win = w;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq("accept_timeout", longint'(n < 100), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    xin = 16'($urandom);
    yin = 16'($urandom);
    win = 16'($urandom);
  endtask

  // Wait for the result (counting edges since accept), hold off, then take it.
  task automatic recv(input int hold, output int xo, output int yo);
    int lat;
    lat = 0;
    out_ready = 1'b0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    // Result appears in the cycle after the NB-th rotation edge.
    check_eq("latency", lat, NB);
    xo = int'(xout);
    yo = int'(yout);
    repeat (hold) begin
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    int  xo, yo, xa, ya, xi, yi, hold;
    real mx, my, ex, ey;
    logic [15:0] w;

    tbl[0] = '{"rot0",     10000, 0, 16'h0000, 16468, 0};
    tbl[1] = '{"rot_pi2",  10000, 0, 16'h4000, 0, 16468};
    tbl[2] = '{"rot_mpi2", 10000, 0, 16'hC000, 0, -16468};
    tbl[3] = '{"rot_pi4",  10000, 0, 16'h2000, 11645, 11645};
    tbl[4] = '{"rot_pi",  -32768, 0, 16'h8000, 53963, 0};

    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    xin = '0;
    yin = '0;
    win = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_in_ready", in_ready, 1);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_xout", xout, 0);
    check_eq("rst_yout", yout, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_eq("idle_in_ready", in_ready, 1);

    for (int k = 0; k < 5; k++) begin
      cordic_model(tbl[k].xi, tbl[k].yi, tbl[k].w, mx, my);
      send(tbl[k].xi, tbl[k].yi, tbl[k].w);
      recv(0, xo, yo);
      check_near({tbl[k].name, "_x_ideal"}, xo, real'(tbl[k].ex), TOL_IDEAL);
      check_near({tbl[k].name, "_y_ideal"}, yo, real'(tbl[k].ey), TOL_IDEAL);
      check_near({tbl[k].name, "_x_model"}, xo, mx, TOL_MODEL);
      check_near({tbl[k].name, "_y_model"}, yo, my, TOL_MODEL);
      check_eq({tbl[k].name, "_idle_ready"}, in_ready, 1);
      check_eq({tbl[k].name, "_idle_valid"}, out_valid, 0);
    end

    // Backpressure: result held in DONE while a second vector waits on in_valid.
    cordic_model(12000, -5000, 16'h1234, mx, my);
    send(12000, -5000, 16'h1234);
    out_ready = 1'b0;
    for (int n = 0; n < 100 && !out_valid; n++) begin
      @(posedge clk); #1;
    end
    check_eq("bp_valid", out_valid, 1);
    xa = int'(xout);
    ya = int'(yout);
    check_near("bp_x", xa, mx, TOL_MODEL);
    check_near("bp_y", ya, my, TOL_MODEL);
    xin = 16'(-7000);
    yin = 16'(9000);
    win = 16'hA5A5;
    in_valid = 1'b1;
    for (int n = 0; n < 10; n++) begin
      @(posedge clk); #1;
      check_eq("bp_hold_valid", out_valid, 1);
      check_eq("bp_hold_ready", in_ready, 0);
      check_eq("bp_hold_x", xout, xa);
      check_eq("bp_hold_y", yout, ya);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_eq("bp_release_ready", in_ready, 1);
    check_eq("bp_release_valid", out_valid, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    xin = 16'($urandom);
    yin = 16'($urandom);
    win = 16'($urandom);
    check_eq("bp_b_accepted", in_ready, 0);
    cordic_model(-7000, 9000, 16'hA5A5, mx, my);
    recv(0, xo, yo);
    check_near("bp_b_x", xo, mx, TOL_MODEL);
    check_near("bp_b_y", yo, my, TOL_MODEL);

    // Asynchronous reset partway through the rotation (iteration 5).
    send(-20000, 15000, 16'h6000);
    repeat (5) begin
      @(posedge clk); #1;
    end
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("abort_in_ready", in_ready, 1);
    check_eq("abort_out_valid", out_valid, 0);
    check_eq("abort_xout", xout, 0);
    check_eq("abort_yout", yout, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cordic_model(5000, 5000, 16'hE000, mx, my);
    send(5000, 5000, 16'hE000);
    recv(1, xo, yo);
    check_near("post_abort_x", xo, mx, TOL_MODEL);
    check_near("post_abort_y", yo, my, TOL_MODEL);

    // Random sweep; expected results queued at accept and retired in order.
    for (int v = 0; v < 1000; v++) begin
      xi = int'($urandom_range(65535)) - 32768;
      yi = int'($urandom_range(65535)) - 32768;
      w  = 16'($urandom);
      hold = int'($urandom_range(3));
      repeat ($urandom_range(2)) begin
        @(posedge clk); #1;
      end
      cordic_model(xi, yi, w, mx, my);
      qx.push_back(mx);
      qy.push_back(my);
      send(xi, yi, w);
      recv(hold, xo, yo);
      ex = qx.pop_front();
      ey = qy.pop_front();
      check_near("rand_x", xo, ex, TOL_MODEL);
      check_near("rand_y", yo, ey, TOL_MODEL);
    end
    check_eq("rand_queue_empty", qx.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
